// File: rtl/uart_irq_ack.sv
// rtl/uart_irq_ack.sv - UART interrupt aggregator: edge-detected sticky pending, mask, priority id, holdoff
module uart_irq_ack #(
  parameter int N_SRC       = 8,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_SRC-1:0]         evt_i,
  input  logic                     mask_wr_i,
  input  logic [N_SRC-1:0]         mask_wdata_i,
  input  logic                     clr_wr_i,
  input  logic [N_SRC-1:0]         clr_wdata_i,
  output logic [N_SRC-1:0]         pending_o,
  output logic [N_SRC-1:0]         mask_o,
  output logic                     irq_o,
  output logic [$clog2(N_SRC)-1:0] irq_id_o,
  output logic                     irq_valid_o
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = (HOLDOFF_CYC == 0) ? 1 : $clog2(HOLDOFF_CYC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [N_SRC-1:0] evt_q, evt_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic             irq_q, irq_d;

  logic [N_SRC-1:0] evt_edge;
  logic [N_SRC-1:0] clr_bits;
  logic [N_SRC-1:0] active;
  logic [IW-1:0]    irq_id;

  assign evt_edge = evt_i & ~evt_q;
  assign clr_bits = clr_wr_i ? clr_wdata_i : '0;
  assign active   = pending_q & mask_q;

  // A new edge overrides a simultaneous write-one-to-clear of the same bit.
  always_comb begin
    evt_d     = evt_i;
    pending_d = (pending_q & ~clr_bits) | evt_edge;
    mask_d    = mask_wr_i ? mask_wdata_i : mask_q;
  end

  // Scan high to low so the lowest active index wins.
  always_comb begin
    irq_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) irq_id = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (active != '0) state_d = ASSERT;
      end
      ASSERT: begin
        if (active == '0) begin
          if (HOLDOFF_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    irq_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      evt_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
    end else begin
      evt_q     <= evt_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
    end
  end

  assign pending_o   = pending_q;
  assign mask_o      = mask_q;
  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id;
  assign irq_valid_o = (active != '0);

endmodule

// File: tb/tb_uart_irq_ack.sv
// tb/tb_uart_irq_ack.sv - randomized and directed bench for uart_irq_ack against a cycle-level reference model
module tb_uart_irq_ack;

  localparam int N    = 8;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] evt, mask_wd, clr_wd;
  logic         mask_wr, clr_wr;
  logic [N-1:0] pending, mask;
  logic         irq, irq_valid;
  logic [2:0]   irq_id;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] m_pend, m_mask, m_evtq;
  logic         m_irq;
  int           m_quiet;

  uart_irq_ack #(.N_SRC(N), .HOLDOFF_CYC(HOLD)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .evt_i        (evt),
    .mask_wr_i    (mask_wr),
    .mask_wdata_i (mask_wd),
    .clr_wr_i     (clr_wr),
    .clr_wdata_i  (clr_wd),
    .pending_o    (pending),
    .mask_o       (mask),
    .irq_o        (irq),
    .irq_id_o     (irq_id),
    .irq_valid_o  (irq_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Model: irq rises one edge after any source is active, unless a quiet
  // period of HOLD edges (started on the edge irq fell) is still running.
  task automatic model_edge();
    logic [N-1:0] act;
    if (!rstn) begin
      m_pend = '0; m_mask = '0; m_evtq = '0; m_irq = 1'b0; m_quiet = 0;
    end else begin
      act = m_pend & m_mask;
      if (m_irq) begin
        if (act == '0) begin
          m_irq   = 1'b0;
          m_quiet = HOLD;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (act != '0) begin
        m_irq = 1'b1;
      end
      m_pend = (m_pend & ~(clr_wr ? clr_wd : '0)) | (evt & ~m_evtq);
      if (mask_wr) m_mask = mask_wd;
      m_evtq = evt;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] e,
                      input logic mw, input logic [N-1:0] md,
                      input logic cw, input logic [N-1:0] cd);
    logic [N-1:0] act;
    rstn = r; evt = e; mask_wr = mw; mask_wd = md; clr_wr = cw; clr_wd = cd;
    model_edge();
    @(posedge clk);
    #1;
    act = m_pend & m_mask;
    check("pending", 32'(pending), 32'(m_pend));
    check("mask", 32'(mask), 32'(m_mask));
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_valid", 32'(irq_valid), 32'(act != '0));
    check("irq_id", 32'(irq_id), 32'(lowest_set(act)));
  endtask

  task automatic idle(input logic [N-1:0] e, input int n);
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    m_pend = '0; m_mask = '0; m_evtq = '0; m_irq = 1'b0; m_quiet = 0;
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // single pulse on bit 3 with all sources enabled
    step(1'b1, '0, 1'b1, 8'hFF, 1'b0, '0);
    step(1'b1, 8'h08, 1'b0, '0, 1'b0, '0);
    check("pulse_pending", 32'(pending), 32'h08);
    check("pulse_irq_k", 32'(irq), 32'h0);
    step(1'b1, 8'h00, 1'b0, '0, 1'b0, '0);
    check("pulse_irq_k1", 32'(irq), 32'h1);
    check("pulse_id", 32'(irq_id), 32'h3);

    // priority and clear ordering
    step(1'b1, 8'h20, 1'b0, '0, 1'b0, '0);
    step(1'b1, 8'h00, 1'b0, '0, 1'b0, '0);
    check("prio_id3", 32'(irq_id), 32'h3);
    step(1'b1, 8'h00, 1'b0, '0, 1'b1, 8'h08);
    check("prio_id5", 32'(irq_id), 32'h5);
    check("prio_irq_held", 32'(irq), 32'h1);
    step(1'b1, 8'h00, 1'b0, '0, 1'b1, 8'h20);
    step(1'b1, 8'h00, 1'b0, '0, 1'b0, '0);
    check("clr_irq_low", 32'(irq), 32'h0);
    idle('0, 20);

    // set wins over simultaneous clear
    step(1'b1, 8'h01, 1'b0, '0, 1'b1, 8'h01);
    check("set_wins", 32'(pending[0]), 32'h1);
    step(1'b1, 8'h00, 1'b0, '0, 1'b1, 8'hFF);
    idle('0, 20);

    // masked event, then unmask
    step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, '0);
    step(1'b1, 8'h04, 1'b0, '0, 1'b0, '0);
    step(1'b1, 8'h00, 1'b0, '0, 1'b0, '0);
    check("masked_pending", 32'(pending), 32'h04);
    check("masked_irq", 32'(irq), 32'h0);
    step(1'b1, 8'h00, 1'b1, 8'h04, 1'b0, '0);
    check("unmask_irq_w", 32'(irq), 32'h0);
    step(1'b1, 8'h00, 1'b0, '0, 1'b0, '0);
    check("unmask_irq_w1", 32'(irq), 32'h1);

    // event arrives mid-holdoff
    step(1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h04);
    idle('0, 5);
    step(1'b1, 8'h02, 1'b0, '0, 1'b0, '0);
    idle(8'h02, 20);

    // reset during assert with everything pending, bit 1 held through it
    step(1'b1, 8'hFF, 1'b0, '0, 1'b0, '0);
    step(1'b1, 8'h02, 1'b0, '0, 1'b0, '0);
    check("pre_rst_irq", 32'(irq), 32'h1);
    step(1'b0, 8'h02, 1'b0, '0, 1'b0, '0);
    check("rst_mid_pending", 32'(pending), 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    check("rst_mid_valid", 32'(irq_valid), 32'h0);
    step(1'b1, 8'h02, 1'b0, '0, 1'b0, '0);
    check("post_rst_pending", 32'(pending), 32'h02);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0),
           N'($urandom()) & N'($urandom()),
           ($urandom_range(0, 7) == 0), N'($urandom()),
           ($urandom_range(0, 3) == 0), N'($urandom()));
      if ($urandom_range(0, 15) == 0) idle('0, $urandom_range(5, 25));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_irq_ack.md
UART_IRQ_ACK -- requirements
Module: uart_irq_ack

Interface
REQ-001 SHALL provide parameter N_SRC, default 8, number of interrupt event sources (legal range 2..32).
REQ-002 SHALL provide parameter HOLDOFF_CYC, default 16, minimum number of idle cycles on irq_o after deassertion (legal range 0..65535).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port evt_i, input, N_SRC bits: raw event lines from the UART core; a rising edge signals an event.
REQ-007 SHALL have port mask_wr_i, input, 1 bit: write strobe for the mask register.
REQ-008 SHALL have port mask_wdata_i, input, N_SRC bits: new mask value; 1 = source enabled.
REQ-009 SHALL have port clr_wr_i, input, 1 bit: write-one-to-clear strobe for the pending register.
REQ-010 SHALL have port clr_wdata_i, input, N_SRC bits: pending bits to clear.
REQ-011 SHALL have port pending_o, output, N_SRC bits: sticky pending register.
REQ-012 SHALL have port mask_o, output, N_SRC bits: current mask register.
REQ-013 SHALL have port irq_o, output, 1 bit: registered level interrupt to the host.
REQ-014 SHALL have port irq_id_o, output, $clog2(N_SRC) bits: index of the highest-priority active source.
REQ-015 SHALL have port irq_valid_o, output, 1 bit: at least one pending-and-enabled source exists.

Function
REQ-016 SHALL register evt_i into evt_q every cycle; a source's edge = evt_i & ~evt_q.
REQ-017 SHALL set pending bit i on the clock edge where edge[i]=1; pending_o shows it after that edge, regardless of mask.
REQ-018 SHALL clear pending bit i on a clock edge where clr_wr_i=1 and clr_wdata_i[i]=1.
REQ-019 SHALL let set win over clear when edge[i] and the clear of bit i occur on the same edge.
REQ-020 SHALL load mask_o from mask_wdata_i on edges where mask_wr_i=1; the new mask takes effect for irq_id_o/irq_valid_o in the following cycle.
REQ-021 SHALL define active = pending_o & mask_o.
REQ-022 SHALL drive irq_valid_o = |active, combinationally from registers.
REQ-023 SHALL drive irq_id_o = lowest index i with active[i]=1 (index 0 highest priority), and 0 when active==0.
REQ-024 SHALL implement an FSM with states IDLE, ASSERT and HOLDOFF.
REQ-025 In IDLE with active!=0, the FSM SHALL go to ASSERT.
REQ-026 In ASSERT with active==0, the FSM SHALL go to HOLDOFF and load the counter with HOLDOFF_CYC; if HOLDOFF_CYC==0, it SHALL go directly to IDLE.
REQ-027 In HOLDOFF, the FSM SHALL decrement the counter each cycle and go to IDLE on the edge where the counter equals 1; activity arriving during HOLDOFF SHALL be ignored until IDLE.
REQ-028 SHALL drive irq_o = 1 exactly when the state is ASSERT (registered, glitch-free).
REQ-029 Latency: evt_i rising sampled at edge k gives pending_o=1 after edge k and irq_o=1 after edge k+1 (from IDLE, with the bit unmasked).
REQ-030 SHALL size the holdoff counter at $clog2(HOLDOFF_CYC+1) bits, minimum 1 bit; it never wraps.
REQ-031 An event held high SHALL set pending only once; re-setting requires a low-then-high transition.
REQ-032 Masking all active sources while in ASSERT SHALL deassert irq_o via HOLDOFF, exactly as a clear does.

Reset
REQ-033 On an edge with rstn_i=0, the block SHALL set pending_o=0, mask_o=0, evt_q=0, FSM=IDLE, counter=0, irq_o=0; irq_id_o=0 and irq_valid_o=0 follow.
REQ-034 Reset mid-ASSERT or mid-HOLDOFF SHALL abort to IDLE on that edge; an evt_i held high through reset SHALL produce an edge on the first cycle after release.

Verification
REQ-035 mask=0xFF, pulse evt_i[3] for 1 cycle at edge k -> pending_o=0x08 after edge k, irq_o=1 after edge k+1, irq_id_o=3.
REQ-036 pending=0x28 with mask=0xFF -> irq_id_o=3; W1C 0x08 -> irq_id_o=5, irq_o remains 1; W1C 0x20 -> irq_o=0, HOLDOFF lasting 16 cycles.
REQ-037 evt_i[0] edge on the same edge as W1C 0x01 -> pending_o[0]=1 (set wins).
REQ-038 mask=0x00, event on bit 2 -> pending_o=0x04, irq_o=0; then write mask=0x04 -> irq_o=1 two cycles after the write.
REQ-039 New event during HOLDOFF (HOLDOFF_CYC=16) -> irq_o stays 0 until the counter expires, then reasserts 1 cycle after IDLE.
REQ-040 rstn_i=0 during ASSERT with pending=0xFF -> all outputs 0 after the edge; evt_i[1] held high across reset -> pending_o=0x02 one cycle after release.
